// File: rtl/carfield_mailbox_unit.sv
// carfield_mailbox_unit: register-bus mailbox bank with per-mailbox doorbell irqs and two letter registers.
// Optional CARFIELD_MBOX_LETTER_LOCK_EN: letter writes are refused while the mailbox RCV_STAT is set.
module carfield_mailbox_unit #(
    parameter int NumMbox   = 16,
    parameter int AddrWidth = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [3:0]           req_wstrb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic [NumMbox-1:0]   snd_irq_o,
    output logic [NumMbox-1:0]   rcv_irq_o
);
    localparam int MW = AddrWidth - 6;

    typedef enum logic {IDLE, RESP} state_t;

    state_t             state_q, state_n;
    logic [NumMbox-1:0] snd_stat_q, snd_stat_n, snd_en_q, snd_en_n;
    logic [NumMbox-1:0] rcv_stat_q, rcv_stat_n, rcv_en_q, rcv_en_n;
    logic [NumMbox-1:0] snd_irq_q, rcv_irq_q;
    logic [31:0]        letter_q [NumMbox][2];
    logic [31:0]        letter_n [NumMbox][2];
    logic [31:0]        rdata_q, rd;
    logic               error_q, error_n, hit, lock, accept, commit;
    logic [MW-1:0]      mbox;
    logic [5:0]         off;

    assign mbox   = req_addr_i[AddrWidth-1:6];
    assign off    = req_addr_i[5:0];
    assign accept = (state_q == IDLE) && req_valid_i;
    assign commit = accept && req_write_i && !error_n;

    // Decode and read mux; values are those held before this edge's commit.
    always_comb begin
        hit  = 1'b0;
        lock = 1'b0;
        rd   = '0;
        for (int i = 0; i < NumMbox; i++) begin
            if (mbox == MW'(i)) begin
                hit = 1'b1;
`ifdef CARFIELD_MBOX_LETTER_LOCK_EN
                lock = req_write_i && rcv_stat_q[i] && (off == 6'h20 || off == 6'h24);
`endif
                case (off)
                    6'h00:   rd = {31'b0, snd_stat_q[i]};
                    6'h0C:   rd = {31'b0, snd_en_q[i]};
                    6'h10:   rd = {31'b0, rcv_stat_q[i]};
                    6'h1C:   rd = {31'b0, rcv_en_q[i]};
                    6'h20:   rd = letter_q[i][0];
                    6'h24:   rd = letter_q[i][1];
                    default: rd = '0;
                endcase
            end
        end
        error_n = !hit || (req_addr_i[1:0] != 2'b00) || (off >= 6'h28) ||
                  (req_write_i && (off == 6'h00 || off == 6'h10)) || lock;
    end

    always_comb begin
        snd_stat_n = snd_stat_q;
        snd_en_n   = snd_en_q;
        rcv_stat_n = rcv_stat_q;
        rcv_en_n   = rcv_en_q;
        letter_n   = letter_q;
        for (int i = 0; i < NumMbox; i++) begin
            if (commit && mbox == MW'(i)) begin
                case (off)
                    6'h04:   snd_stat_n[i] = snd_stat_q[i] | (req_wstrb_i[0] & req_wdata_i[0]);
                    6'h08:   snd_stat_n[i] = snd_stat_q[i] & ~(req_wstrb_i[0] & req_wdata_i[0]);
                    6'h0C:   snd_en_n[i]   = req_wstrb_i[0] ? req_wdata_i[0] : snd_en_q[i];
                    6'h14:   rcv_stat_n[i] = rcv_stat_q[i] | (req_wstrb_i[0] & req_wdata_i[0]);
                    6'h18:   rcv_stat_n[i] = rcv_stat_q[i] & ~(req_wstrb_i[0] & req_wdata_i[0]);
                    6'h1C:   rcv_en_n[i]   = req_wstrb_i[0] ? req_wdata_i[0] : rcv_en_q[i];
                    6'h20, 6'h24:
                        for (int b = 0; b < 4; b++)
                            if (req_wstrb_i[b])
                                letter_n[i][off[2]][8*b +: 8] = req_wdata_i[8*b +: 8];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_n     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                state_n     = req_valid_i ? RESP : IDLE;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_n     = rsp_ready_i ? IDLE : RESP;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            snd_stat_q <= '0;
            snd_en_q   <= '0;
            rcv_stat_q <= '0;
            rcv_en_q   <= '0;
            snd_irq_q  <= '0;
            rcv_irq_q  <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            for (int i = 0; i < NumMbox; i++) begin
                letter_q[i][0] <= '0;
                letter_q[i][1] <= '0;
            end
        end else begin
            state_q    <= state_n;
            snd_stat_q <= snd_stat_n;
            snd_en_q   <= snd_en_n;
            rcv_stat_q <= rcv_stat_n;
            rcv_en_q   <= rcv_en_n;
            letter_q   <= letter_n;
            // irqs registered from next-state so they rise right after the accepting edge
            snd_irq_q  <= snd_stat_n & snd_en_n;
            rcv_irq_q  <= rcv_stat_n & rcv_en_n;
            if (accept) begin
                rdata_q <= (req_write_i || error_n) ? 32'h0 : rd;
                error_q <= error_n;
            end
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = error_q;
    assign snd_irq_o   = snd_irq_q;
    assign rcv_irq_o   = rcv_irq_q;
endmodule

// File: tb/tb_carfield_mailbox_unit.sv
// tb_carfield_mailbox_unit: directed and randomized checks of the mailbox against a behavioural model.
module tb_carfield_mailbox_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0, rsp_rdata;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_error;
    logic [15:0] snd_irq, rcv_irq;

    int n_cmp = 0, n_bad = 0;

    bit          m_sst[16], m_sen[16], m_rst[16], m_ren[16];
    bit [31:0]   m_let[16][2];
    bit          exp_busy, exp_err;
    bit [31:0]   exp_rd;

    carfield_mailbox_unit dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_error_o(rsp_error), .snd_irq_o(snd_irq), .rcv_irq_o(rcv_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register-map semantics applied directly to the model arrays.
    function automatic void model(input bit [11:0] a, input bit w, input bit [31:0] d,
                                  input bit [3:0] s, output bit [31:0] r, output bit e);
        int mb = int'(a) / 64;
        int of = int'(a) % 64;
        e = mb >= 16 || a[1:0] != 2'b00 || of >= 40 || (w && (of == 0 || of == 16));
`ifdef CARFIELD_MBOX_LETTER_LOCK_EN
        if (!e && w && (of == 32 || of == 36) && m_rst[mb]) e = 1'b1;
`endif
        r = 32'h0;
        if (e) return;
        if (!w) begin
            case (of)
                0:  r = 32'(m_sst[mb]);
                12: r = 32'(m_sen[mb]);
                16: r = 32'(m_rst[mb]);
                28: r = 32'(m_ren[mb]);
                32: r = m_let[mb][0];
                36: r = m_let[mb][1];
                default: r = 32'h0;
            endcase
        end else begin
            case (of)
                4:  if (s[0] && d[0]) m_sst[mb] = 1'b1;
                8:  if (s[0] && d[0]) m_sst[mb] = 1'b0;
                12: if (s[0]) m_sen[mb] = d[0];
                20: if (s[0] && d[0]) m_rst[mb] = 1'b1;
                24: if (s[0] && d[0]) m_rst[mb] = 1'b0;
                28: if (s[0]) m_ren[mb] = d[0];
                32, 36: for (int b = 0; b < 4; b++)
                    if (s[b]) m_let[mb][(of - 32) / 4][8*b +: 8] = d[8*b +: 8];
                default: ;
            endcase
        end
    endfunction

    function automatic bit [15:0] irqv(input bit rcv);
        bit [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = rcv ? (m_rst[i] & m_ren[i]) : (m_sst[i] & m_sen[i]);
        return v;
    endfunction

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_sst[i] = 0; m_sen[i] = 0; m_rst[i] = 0; m_ren[i] = 0;
                m_let[i][0] = 0; m_let[i][1] = 0;
            end
            exp_busy = 0; exp_rd = 0; exp_err = 0;
        end else if (!exp_busy) begin
            if (req_valid) begin
                model(req_addr, req_write, req_wdata, req_wstrb, exp_rd, exp_err);
                exp_busy = 1;
            end
        end else if (rsp_ready) exp_busy = 0;
    end

    always begin
        @(negedge clk);
        if (rst_n) begin
            chk("req_ready", 32'(req_ready), 32'(!exp_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_busy));
            chk("snd_irq", 32'(snd_irq), 32'(irqv(1'b0)));
            chk("rcv_irq", 32'(rcv_irq), 32'(irqv(1'b1)));
            if (exp_busy) begin
                chk("rsp_rdata", rsp_rdata, exp_rd);
                chk("rsp_error", 32'(rsp_error), 32'(exp_err));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic xact(input logic [11:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input int hold,
                        output logic [31:0] rd, output logic e);
        int n = 0;
        req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d; req_wstrb = s;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 8);
        req_valid = 1'b0;
        chk("latency", 32'(n), 32'd1);
        rd = rsp_rdata;
        e  = rsp_error;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h020;
            req_wdata = '1; req_wstrb = '1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_irqs", {snd_irq, rcv_irq}, 32'd0);

        xact(12'h020, 1'b0, 32'h0, 4'h0, 0, rd, e);
        chk("t1_rd", rd, 32'h0);
        chk("t1_err", 32'(e), 32'd0);

        xact(12'h060, 1'b1, 32'hDEADBEEF, 4'b0101, 0, rd, e);
        chk("t2_werr", 32'(e), 32'd0);
        xact(12'h060, 1'b0, 32'h0, 4'h0, 0, rd, e);
        chk("t2_rd", rd, 32'h00AD00EF);

        xact(12'h0DC, 1'b1, 32'h1, 4'h1, 0, rd, e);
        xact(12'h0D4, 1'b1, 32'h1, 4'h1, 0, rd, e);
        chk("t3_irq_on", 32'(rcv_irq), 32'h0008);
        xact(12'h0D0, 1'b0, 32'h0, 4'h0, 0, rd, e);
        chk("t3_stat", rd, 32'h1);
        xact(12'h0D8, 1'b1, 32'h1, 4'h1, 0, rd, e);
        chk("t3_irq_off", {snd_irq, rcv_irq}, 32'h0);

        xact(12'h060, 1'b0, 32'h0, 4'h0, 5, rd, e);
        chk("t4_rd", rd, 32'h00AD00EF);
        xact(12'h020, 1'b0, 32'h0, 4'h0, 0, rd, e);
        chk("t4_nospurious", rd, 32'h0);

        xact(12'h400, 1'b0, 32'h0, 4'h0, 0, rd, e);
        chk("t5_oob_err", 32'(e), 32'd1);
        chk("t5_oob_rd", rd, 32'h0);
        xact(12'h021, 1'b1, 32'hFFFFFFFF, 4'hF, 0, rd, e);
        chk("t5_unal_err", 32'(e), 32'd1);
        xact(12'h010, 1'b1, 32'h1, 4'hF, 0, rd, e);
        chk("t5_ro_err", 32'(e), 32'd1);
        xact(12'h010, 1'b0, 32'h0, 4'h0, 0, rd, e);
        chk("t5_ro_keep", rd, 32'h0);
        xact(12'h028, 1'b0, 32'h0, 4'h0, 0, rd, e);
        chk("t5_rsv_err", 32'(e), 32'd1);
        xact(12'h020, 1'b0, 32'h0, 4'h0, 0, rd, e);
        chk("t5_letter_keep", rd, 32'h0);

        xact(12'h014, 1'b1, 32'h1, 4'h1, 0, rd, e);
        xact(12'h020, 1'b1, 32'h12345678, 4'hF, 0, rd, e);
`ifdef CARFIELD_MBOX_LETTER_LOCK_EN
        chk("t6_lock_err", 32'(e), 32'd1);
        xact(12'h020, 1'b0, 32'h0, 4'h0, 0, rd, e);
        chk("t6_lock_rd", rd, 32'h0);
`else
        chk("t6_lock_err", 32'(e), 32'd0);
        xact(12'h020, 1'b0, 32'h0, 4'h0, 0, rd, e);
        chk("t6_lock_rd", rd, 32'h12345678);
`endif

        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h0A0;
        req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t7_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(12'h0A0, 1'b0, 32'h0, 4'h0, 0, rd, e);
        chk("t7_cleared", rd, 32'h0);

        for (int k = 0; k < 400; k++) begin
            int mb;
            int of;
            mb = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
            of = int'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 19) == 0) of += int'($urandom_range(1, 3));
            xact(12'(mb * 64 + of), 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                 int'($urandom_range(0, 2)), rd, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/carfield_mailbox_unit.md
Name: carfield_mailbox_unit

Overview:
- Inter-domain mailbox at MailboxBase (0x4000_0000, 4 KiB window), downstream of the host AXI external-slave crossbar port MailboxSlvIdx.
- Sits behind an AXI-to-register-interface bridge and exposes NumMbox mailboxes.
- Each mailbox has two 32-bit letter registers, a sender interrupt and a receiver interrupt, so the host, safety island, security island and integer cluster can exchange doorbells and short messages.
- Single-outstanding register-bus slave with a decoupled response handshake.

Parameters:
- NumMbox, 16, number of mailboxes; legal 1..64; each mailbox occupies a 64-byte (0x40) slot.
- AddrWidth, 12, byte-address width, covering the 4 KiB window.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted this cycle when high with req_valid_i
- req_addr_i  in  AddrWidth  byte address, offset within window
- req_write_i  in  1  1=write, 0=read
- req_wdata_i  in  32  write data
- req_wstrb_i  in  4  byte strobes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  32  read data; 0 for writes and errors
- rsp_error_o  out  1  access error
- snd_irq_o  out  NumMbox  sender interrupt per mailbox
- rcv_irq_o  out  NumMbox  receiver interrupt per mailbox

Behaviour:
- Address decode:
  - mbox = addr[AddrWidth-1:6]; off = addr[5:0].
  - Per-mailbox map: 0x00 SND_STAT (RO), 0x04 SND_SET (W1S), 0x08 SND_CLR (W1C), 0x0C SND_EN (RW), 0x10 RCV_STAT (RO), 0x14 RCV_SET (W1S), 0x18 RCV_CLR (W1C), 0x1C RCV_EN (RW), 0x20 LETTER0 (RW), 0x24 LETTER1 (RW).
  - STAT/EN are 1-bit, in bit 0; bits 31:1 read 0.
  - SET/CLR/STAT reads return 0 for SET/CLR, current bit for STAT.
- Error (rsp_error_o=1, no state change, rdata 0):
  - mbox >= NumMbox;
  - addr[1:0] != 0;
  - off in 0x28..0x3C;
  - write to SND_STAT or RCV_STAT.
- Writes:
  - LETTERx updates only the bytes with wstrb set.
  - SET/CLR/EN act only if wstrb[0]=1, using wdata[0].
  - wstrb=0 is a legal no-op with error=0.
- FSM with two states, IDLE and RESP:
  - IDLE: req_ready_o=1. On req_valid_i, commit write state at that edge, latch rdata/error, go to RESP.
  - RESP: req_ready_o=0, rsp_valid_o=1, rsp_rdata_o/rsp_error_o held stable. On rsp_ready_i, go to IDLE.
  - Minimum throughput: one access per 2 cycles. Latency: response visible the cycle after acceptance.
  - No combinational path from req_valid_i or rsp_ready_i to req_ready_o.
- Reads return register values as of the acceptance cycle.
- Interrupts:
  - snd_irq_o[i] = SND_STAT[i] & SND_EN[i]; rcv_irq_o[i] = RCV_STAT[i] & RCV_EN[i].
  - Both are driven from flops with no further logic: level-sensitive, asserted the cycle after the accepting edge.
  - Disabling EN masks the irq but preserves STAT.
  - Writing SET when STAT is already 1 keeps STAT=1; writing CLR when STAT is already 0 is a no-op.
- Reset values: all STAT, EN and LETTER registers 0; FSM IDLE; req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, irqs 0.
- Reset asserted mid-transaction discards any pending response immediately (asynchronous). A write already committed at an earlier edge is also cleared.

Optional Feature:
- Macro CARFIELD_MBOX_LETTER_LOCK_EN.
- With the macro defined: a write to LETTER0/LETTER1 of mailbox i while RCV_STAT[i]=1 is dropped and returns rsp_error_o=1. This prevents overwriting an unread message.
- Without the macro: letter writes always succeed regardless of RCV_STAT.
- Reads are unaffected in both configurations.

Test Plan:
- Reset, then read 0x020 (mbox0 LETTER0) -> rdata 0x0, error 0; req_ready_o=1, all irqs 0 after reset.
- Write 0x060 = 0xDEADBEEF, wstrb 0b0101 -> readback 0x00AD00EF; response appears exactly one cycle after acceptance.
- Write mbox3 RCV_EN (0x0DC) = 1, then RCV_SET (0x0D4) = 1:
  - rcv_irq_o[3] rises the cycle after the SET acceptance; RCV_STAT reads 1.
  - Write RCV_CLR = 1 -> irq falls next cycle; other irq bits stay 0.
- Hold rsp_ready_i=0 for 5 cycles after a read -> rsp_valid_o and rsp_rdata_o stable, req_ready_o=0 throughout; no second request is accepted.
- Errors, each -> error=1 and no state change:
  - read 0x400 with NumMbox=16;
  - write 0x021 (unaligned);
  - write 0x010 (RO STAT);
  - read 0x028 (reserved).
- Lock feature: with RCV_STAT[0]=1, write LETTER0 = 0x12345678.
  - CARFIELD_MBOX_LETTER_LOCK_EN defined -> error=1, LETTER0 unchanged.
  - Undefined -> error=0, readback 0x12345678.
